// File: rtl/rf_alu_engine.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu_engine
// Description : Register file plus ALU engine with a valid/ready command port,
//               a held result port, an external write port and a debug read port.
//               Optional iterative multiplier enabled by macro RF_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_alu_engine #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int SH_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_we,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_zero,
    output logic              res_ovf,
    output logic              res_err,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [WIDTH-1:0]  ext_wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int         c_DEPTH  = 2**ADDR_W;
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SLT = 4'd5;
    localparam logic [3:0] c_OP_SLTU= 4'd6;
    localparam logic [3:0] c_OP_SLL = 4'd7;
    localparam logic [3:0] c_OP_SRL = 4'd8;
    localparam logic [3:0] c_OP_SRA = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_rf [c_DEPTH];
    logic [WIDTH-1:0]    r_res_data;
    logic                r_res_zero;
    logic                r_res_ovf;
    logic                r_res_err;

    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_is_mul;
    logic                w_mul_last;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [SH_W-1:0]     w_shamt;
    logic [WIDTH-1:0]    w_sum;
    logic [WIDTH-1:0]    w_diff;
    logic [WIDTH-1:0]    w_alu;
    logic                w_ovf;
    logic                w_err;
    logic                w_wb_en;
    logic [ADDR_W-1:0]   w_wb_addr;
    logic [WIDTH-1:0]    w_wb_data;

    assign w_cmd_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && res_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign cmd_ready   = w_cmd_ready;

    assign w_a     = (cmd_rs1 == '0) ? '0 : r_rf[cmd_rs1];
    assign w_b     = (cmd_rs2 == '0) ? '0 : r_rf[cmd_rs2];
    assign w_shamt = w_b[SH_W-1:0];
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (cmd_op)
            c_OP_ADD: begin
                w_alu = w_sum;
                w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_alu = w_diff;
                w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_OP_AND:  w_alu = w_a & w_b;
            c_OP_OR:   w_alu = w_a | w_b;
            c_OP_XOR:  w_alu = w_a ^ w_b;
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            c_OP_SLL:  w_alu = w_a << w_shamt;
            c_OP_SRL:  w_alu = w_a >> w_shamt;
            c_OP_SRA:  w_alu = $unsigned($signed(w_a) >>> w_shamt);
            // MUL (when built) takes its own path; everything else is illegal
            default:   w_err = 1'b1;
        endcase
    end

`ifdef RF_ALU_MUL_EN
    localparam logic [3:0] c_OP_MUL = 4'd10;
    localparam int         c_CNT_W  = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_mul_rd;
    logic               r_mul_we;
    logic [WIDTH-1:0]   w_acc_nxt;

    assign w_is_mul   = (cmd_op == c_OP_MUL);
    assign w_mul_last = (r_state == S_MUL_RUN) && (r_cnt == c_CNT_W'(1));
    assign w_acc_nxt  = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    // Shift-add: one multiplier bit per cycle, operands frozen at accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mul_rd <= '0;
            r_mul_we <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mul_a  <= w_a;
            r_mul_b  <= w_b;
            r_acc    <= '0;
            r_cnt    <= c_CNT_W'(WIDTH);
            r_mul_rd <= cmd_rd;
            r_mul_we <= cmd_we;
        end else if (r_state == S_MUL_RUN) begin
            r_acc   <= w_acc_nxt;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_cnt   <= r_cnt - c_CNT_W'(1);
        end
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_last = 1'b0;
`endif

    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_addr = cmd_rd;
        w_wb_data = w_alu;
        if (w_accept && !w_is_mul) begin
            w_wb_en = cmd_we && !w_err && (cmd_rd != '0);
        end
`ifdef RF_ALU_MUL_EN
        if (w_mul_last) begin
            w_wb_en   = r_mul_we && (r_mul_rd != '0);
            w_wb_addr = r_mul_rd;
            w_wb_data = w_acc_nxt;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_is_mul ? S_MUL_RUN : S_DONE;
            end
            S_MUL_RUN: begin
                if (w_mul_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept)       w_state_nxt = w_is_mul ? S_MUL_RUN : S_DONE;
                else if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_data <= '0;
            r_res_zero <= 1'b0;
            r_res_ovf  <= 1'b0;
            r_res_err  <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_res_data <= w_alu;
            r_res_zero <= (w_alu == '0);
            r_res_ovf  <= w_ovf;
            r_res_err  <= w_err;
        end else if (w_mul_last) begin
            r_res_data <= w_wb_data;
            r_res_zero <= (w_wb_data == '0);
            r_res_ovf  <= 1'b0;
            r_res_err  <= 1'b0;
        end
    end

    // Engine write is issued last so it wins a same-address collision
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < c_DEPTH; i++) r_rf[i] <= WIDTH'(i);
        end else begin
            if (ext_we && (ext_addr != '0)) r_rf[ext_addr] <= ext_wdata;
            if (w_wb_en)                    r_rf[w_wb_addr] <= w_wb_data;
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign res_ovf   = r_res_ovf;
    assign res_err   = r_res_err;
    assign dbg_data  = r_rf[dbg_addr];

endmodule
`default_nettype wire
